// File: rtl/cr_iu_vec_pkg.sv
// Shared definitions for the interrupt vector-fetch unit: FSM state encodings
// and vector-table entry geometry.
package cr_iu_vec_pkg;

    localparam int VEC_ENTRY_BYTES = 4;
    localparam int VEC_ENTRY_SHIFT = $clog2(VEC_ENTRY_BYTES);

    typedef enum logic [3:0] {
        ST_RESET      = 4'd0,
        ST_IDLE       = 4'd1,
        ST_NV_WAIT    = 4'd2,
        ST_NV_IDLE    = 4'd3,
        ST_BUF        = 4'd4,
        ST_WAIT_IDLE  = 4'd5,
        ST_WAIT_GRANT = 4'd6,
        ST_WAIT_DATA  = 4'd7,
        ST_VEC_ERR    = 4'd8
    } vec_state_e;

endpackage

// File: rtl/cr_iu_vec_retry_cnt.sv
// Table-fetch retry counter, plus the WAIT_DATA response timeout when
// CR_IU_VEC_TIMEOUT_EN is defined.
module cr_iu_vec_retry_cnt #(
    parameter int MAX_RETRY = 2,
    parameter int TMO_CYC   = 64
) (
    input  logic       misc_clk,
    input  logic       cpurst_b,
    input  logic       cnt_clr,
    input  logic       cnt_inc,
`ifdef CR_IU_VEC_TIMEOUT_EN
    input  logic       in_wait_data,
    input  logic       wait_entry,
    output logic       tmo_hit,
`endif
    output logic [2:0] retry_cnt,
    output logic       at_limit
);

    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

    logic [2:0] retry_q;
    logic [2:0] retry_d;

    always_comb begin
        retry_d = retry_q;
        if (cnt_clr) begin
            retry_d = 3'd0;
        end else if (cnt_inc && (retry_q < MAX_R)) begin
            retry_d = retry_q + 3'd1;
        end
    end

    always_ff @(posedge misc_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            retry_q <= 3'd0;
        end else begin
            retry_q <= retry_d;
        end
    end

    assign retry_cnt = retry_q;
    assign at_limit  = (retry_q >= MAX_R);

`ifdef CR_IU_VEC_TIMEOUT_EN
    // Counts cycles spent in WAIT_DATA; the last count of the window fires.
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    logic [7:0] tmo_q;
    logic [7:0] tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (wait_entry) begin
            tmo_d = 8'd0;
        end else if (in_wait_data && (tmo_q != TMO_LAST)) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    always_ff @(posedge misc_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = in_wait_data && (tmo_q == TMO_LAST);
`endif

endmodule

// File: rtl/cr_iu_vec_fetch.sv
// Interrupt vector fetch: reads the handler address from the vector table on
// the instruction bus. Optional response timeout: CR_IU_VEC_TIMEOUT_EN.
module cr_iu_vec_fetch
    import cr_iu_vec_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int IDX_W     = 12,
    parameter int MAX_RETRY = 2,
    parameter int TMO_CYC   = 64
) (
    input  logic              misc_clk,
    input  logic              cpurst_b,
    input  logic              clk_en,
    input  logic              expt_vld,
    input  logic              expt_hv,
    input  logic [IDX_W-1:0]  expt_id,
    input  logic [ADDR_W-1:0] vbr,
    input  logic [ADDR_W-1:0] err_vbr,
    input  logic              ldst_wait,
    input  logic              expt_taken,
    input  logic              ibus_idle,
    input  logic              ibus_grnt,
    input  logic              ibus_data_vld,
    input  logic              ibus_acc_err,
    input  logic [ADDR_W-1:0] ibus_rdata,
    output logic              ibus_req,
    output logic [ADDR_W-1:0] ibus_addr,
    output logic              chgflw_vld,
    output logic [ADDR_W-1:0] enter_addr,
    output logic              buf_vbr,
    output logic              stall,
    output logic              fetch_mask,
    output logic              reset_vld,
    output logic              vec_err,
    output logic              vec_succeed,
    output logic [2:0]        retry_cnt
);

    if (ADDR_W < 16 || ADDR_W > 32 || MAX_RETRY < 0 || MAX_RETRY > 7 ||
        TMO_CYC < 2 || TMO_CYC > 255) begin : g_param_range
        $error("cr_iu_vec_fetch: parameter out of range");
    end

    vec_state_e        state_q;
    vec_state_e        state_d;
    logic [IDX_W-1:0]  id_q;
    logic [IDX_W-1:0]  id_d;
    logic              fetch_start;
    logic              data_pulse;
    logic              err_evt;
    logic              retry_evt;
    logic              at_limit;
    logic              tmo_hit;
    logic              unused_lsb;

    assign unused_lsb = ^{vbr[0], err_vbr[0], ibus_rdata[0]};

    assign fetch_start = (state_q == ST_IDLE) && expt_vld && expt_hv;
    assign data_pulse  = (state_q == ST_WAIT_DATA) && ibus_data_vld;
    assign err_evt     = (state_q == ST_WAIT_DATA) && !ibus_data_vld && (ibus_acc_err || tmo_hit);
    assign retry_evt   = err_evt && !at_limit;

    always_comb begin
        state_d = state_q;
        id_d    = fetch_start ? expt_id : id_q;
        case (state_q)
            ST_RESET:      if (clk_en) state_d = ST_IDLE;
            ST_IDLE:       if (expt_vld) state_d = expt_hv ? ST_BUF : ST_NV_WAIT;
            ST_NV_WAIT:    if (!ldst_wait) state_d = ST_NV_IDLE;
            ST_NV_IDLE:    if (expt_taken) state_d = ST_IDLE;
            ST_BUF:        if (!ldst_wait) state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE:  if (ibus_idle) state_d = ibus_grnt ? ST_WAIT_DATA : ST_WAIT_GRANT;
            ST_WAIT_GRANT: if (ibus_grnt) state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: begin
                // Returned data wins over an error flagged in the same cycle.
                if (ibus_data_vld) begin
                    state_d = ST_IDLE;
                end else if (err_evt) begin
                    state_d = at_limit ? ST_VEC_ERR : ST_WAIT_IDLE;
                end
            end
            ST_VEC_ERR:    state_d = ST_IDLE;
            default:       state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge misc_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= ST_RESET;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

`ifdef CR_IU_VEC_TIMEOUT_EN
    logic wait_entry;
    assign wait_entry = (state_d == ST_WAIT_DATA) && (state_q != ST_WAIT_DATA);
`else
    assign tmo_hit = 1'b0;
`endif

    cr_iu_vec_retry_cnt #(
        .MAX_RETRY (MAX_RETRY),
        .TMO_CYC   (TMO_CYC)
    ) u_retry_cnt (
        .misc_clk     (misc_clk),
        .cpurst_b     (cpurst_b),
        .cnt_clr      (fetch_start),
        .cnt_inc      (retry_evt),
`ifdef CR_IU_VEC_TIMEOUT_EN
        .in_wait_data (state_q == ST_WAIT_DATA),
        .wait_entry   (wait_entry),
        .tmo_hit      (tmo_hit),
`endif
        .retry_cnt    (retry_cnt),
        .at_limit     (at_limit)
    );

    // Bus handshake: ibus_req stays high until ibus_grnt is seen, with
    // ibus_addr stable; the response then arrives as ibus_data_vld or ibus_acc_err.
    assign ibus_req  = ((state_q == ST_WAIT_IDLE) && ibus_idle) || (state_q == ST_WAIT_GRANT);
    assign ibus_addr = {vbr[ADDR_W-1:2], 2'b00} + (ADDR_W'(id_q) << VEC_ENTRY_SHIFT);

    assign chgflw_vld = data_pulse || (state_q == ST_VEC_ERR) ||
                        ((state_q == ST_NV_IDLE) && expt_taken);

    always_comb begin
        enter_addr = {vbr[ADDR_W-1:1], 1'b0};
        if (data_pulse) begin
            enter_addr = {ibus_rdata[ADDR_W-1:1], 1'b0};
        end else if (state_q == ST_VEC_ERR) begin
            enter_addr = {err_vbr[ADDR_W-1:1], 1'b0};
        end
    end

    assign buf_vbr     = ((state_q == ST_BUF) && !ldst_wait) ||
                         ((state_q == ST_NV_IDLE) && expt_taken) ||
                         (state_q == ST_VEC_ERR);
    assign stall       = (state_q != ST_IDLE);
    assign fetch_mask  = (state_q != ST_IDLE);
    assign reset_vld   = (state_q == ST_RESET);
    assign vec_err     = (state_q == ST_VEC_ERR);
    assign vec_succeed = data_pulse;

endmodule

// File: tb/tb_cr_iu_vec_fetch.sv
// Directed bench for cr_iu_vec_fetch; timeout steps depend on CR_IU_VEC_TIMEOUT_EN.
module tb_cr_iu_vec_fetch;

    localparam int ADDR_W = 32;
    localparam int IDX_W  = 12;

    logic              misc_clk = 1'b0;
    logic              cpurst_b;
    logic              clk_en;
    logic              expt_vld;
    logic              expt_hv;
    logic [IDX_W-1:0]  expt_id;
    logic [ADDR_W-1:0] vbr;
    logic [ADDR_W-1:0] err_vbr;
    logic              ldst_wait;
    logic              expt_taken;
    logic              ibus_idle;
    logic              ibus_grnt;
    logic              ibus_data_vld;
    logic              ibus_acc_err;
    logic [ADDR_W-1:0] ibus_rdata;
    logic              ibus_req;
    logic [ADDR_W-1:0] ibus_addr;
    logic              chgflw_vld;
    logic [ADDR_W-1:0] enter_addr;
    logic              buf_vbr;
    logic              stall;
    logic              fetch_mask;
    logic              reset_vld;
    logic              vec_err;
    logic              vec_succeed;
    logic [2:0]        retry_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] exp_q[$];

    cr_iu_vec_fetch #(
        .ADDR_W    (ADDR_W),
        .IDX_W     (IDX_W),
        .MAX_RETRY (2),
        .TMO_CYC   (4)
    ) dut (
        .misc_clk      (misc_clk),
        .cpurst_b      (cpurst_b),
        .clk_en        (clk_en),
        .expt_vld      (expt_vld),
        .expt_hv       (expt_hv),
        .expt_id       (expt_id),
        .vbr           (vbr),
        .err_vbr       (err_vbr),
        .ldst_wait     (ldst_wait),
        .expt_taken    (expt_taken),
        .ibus_idle     (ibus_idle),
        .ibus_grnt     (ibus_grnt),
        .ibus_data_vld (ibus_data_vld),
        .ibus_acc_err  (ibus_acc_err),
        .ibus_rdata    (ibus_rdata),
        .ibus_req      (ibus_req),
        .ibus_addr     (ibus_addr),
        .chgflw_vld    (chgflw_vld),
        .enter_addr    (enter_addr),
        .buf_vbr       (buf_vbr),
        .stall         (stall),
        .fetch_mask    (fetch_mask),
        .reset_vld     (reset_vld),
        .vec_err       (vec_err),
        .vec_succeed   (vec_succeed),
        .retry_cnt     (retry_cnt)
    );

    always #5 misc_clk = ~misc_clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge misc_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // A control-flow change must pop the oldest expected entry address.
    task automatic chk_pulse(input string tag);
        chk({tag, "_chgflw"}, ADDR_W'(chgflw_vld), 1);
        n_vec++;
        assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (exp_q.size() > 0) chk({tag, "_enter"}, enter_addr, exp_q.pop_front());
    endtask

    task automatic start_hv(input logic [IDX_W-1:0] id);
        expt_vld = 1'b1;
        expt_hv  = 1'b1;
        expt_id  = id;
        cyc();
        expt_vld = 1'b0;
    endtask

    initial begin
        cpurst_b = 1'b0; clk_en = 1'b0; expt_vld = 1'b0; expt_hv = 1'b0; expt_id = '0;
        vbr = 32'h0000_1000; err_vbr = 32'h0000_8001; ldst_wait = 1'b0; expt_taken = 1'b0;
        ibus_idle = 1'b0; ibus_grnt = 1'b0; ibus_data_vld = 1'b0; ibus_acc_err = 1'b0;
        ibus_rdata = '0;

        // Reset state
        #1;
        chk("rst_reset_vld", ADDR_W'(reset_vld), 1);
        chk("rst_stall", ADDR_W'(stall), 1);
        chk("rst_fetch_mask", ADDR_W'(fetch_mask), 1);
        chk("rst_ibus_req", ADDR_W'(ibus_req), 0);
        chk("rst_chgflw", ADDR_W'(chgflw_vld), 0);
        chk("rst_vec_err", ADDR_W'(vec_err), 0);
        chk("rst_succeed", ADDR_W'(vec_succeed), 0);
        chk("rst_buf_vbr", ADDR_W'(buf_vbr), 0);
        chk("rst_retry", ADDR_W'(retry_cnt), 0);
        cyc(2);
        cpurst_b = 1'b1;
        cyc();
        chk("reset_hold_no_clk_en", ADDR_W'(reset_vld), 1);
        clk_en = 1'b1;
        cyc();
        chk("idle_reset_vld", ADDR_W'(reset_vld), 0);
        chk("idle_stall", ADDR_W'(stall), 0);
        chk("idle_enter_vbr", enter_addr, 32'h0000_1000);

        // Hardware-vectored fetch, grant straight out of WAIT_IDLE
        start_hv(12'd3);
        ldst_wait = 1'b1; #1;
        chk("buf_stall", ADDR_W'(stall), 1);
        chk("buf_wait_buf_vbr", ADDR_W'(buf_vbr), 0);
        cyc();
        ldst_wait = 1'b0; #1;
        chk("buf_exit_buf_vbr", ADDR_W'(buf_vbr), 1);
        cyc();
        ibus_idle = 1'b1; ibus_grnt = 1'b1; #1;
        chk("t1_req", ADDR_W'(ibus_req), 1);
        chk("t1_addr", ibus_addr, 32'h0000_100C);
        cyc();
        ibus_grnt = 1'b0; #1;
        chk("t1_wait_req", ADDR_W'(ibus_req), 0);
        chk("t1_wait_chgflw", ADDR_W'(chgflw_vld), 0);
        ibus_data_vld = 1'b1; ibus_rdata = 32'h0000_2001;
        exp_q.push_back(32'h0000_2000);
        #1;
        chk_pulse("t1");
        chk("t1_succeed", ADDR_W'(vec_succeed), 1);
        cyc();
        ibus_data_vld = 1'b0; #1;
        chk("t1_after_chgflw", ADDR_W'(chgflw_vld), 0);
        chk("t1_after_succeed", ADDR_W'(vec_succeed), 0);
        chk("t1_after_stall", ADDR_W'(stall), 0);

        // Non-vectored entry: 3 cycles of ldst_wait give 4 NV_WAIT cycles
        expt_vld = 1'b1; expt_hv = 1'b0;
        cyc();
        expt_vld = 1'b0; ldst_wait = 1'b1; expt_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ldst_wait = 1'b0;
            #1;
            chk($sformatf("nv_wait%0d_chgflw", i), ADDR_W'(chgflw_vld), 0);
            chk($sformatf("nv_wait%0d_stall", i), ADDR_W'(stall), 1);
            cyc();
        end
        exp_q.push_back(32'h0000_1000);
        #1;
        chk_pulse("nv");
        chk("nv_buf_vbr", ADDR_W'(buf_vbr), 1);
        cyc();
        expt_taken = 1'b0; #1;
        chk("nv_after_stall", ADDR_W'(stall), 0);

        // Three bus errors: two retries then VEC_ERR; address held throughout
        start_hv(12'h010);
        cyc();
        for (int r = 0; r < 3; r++) begin
            ibus_idle = 1'b0; #1;
            chk($sformatf("r%0d_busy_req", r), ADDR_W'(ibus_req), 0);
            cyc();
            ibus_idle = 1'b1; ibus_grnt = (r != 0); #1;
            chk($sformatf("r%0d_req", r), ADDR_W'(ibus_req), 1);
            chk($sformatf("r%0d_addr", r), ibus_addr, 32'h0000_1040);
            cyc();
            if (r == 0) begin
                chk("r0_grant_wait_req", ADDR_W'(ibus_req), 1);
                ibus_grnt = 1'b1;
                cyc();
            end
            ibus_grnt = 1'b0; ibus_acc_err = 1'b1;
            expt_vld = 1'b1; expt_hv = 1'b1; expt_id = 12'd7;
            if (r == 2) exp_q.push_back(32'h0000_8000);
            #1;
            chk($sformatf("r%0d_err_chgflw", r), ADDR_W'(chgflw_vld), 0);
            cyc();
            ibus_acc_err = 1'b0; expt_vld = 1'b0; #1;
            if (r < 2) begin
                chk($sformatf("r%0d_retry_cnt", r), ADDR_W'(retry_cnt), r + 1);
                chk($sformatf("r%0d_addr_hold", r), ibus_addr, 32'h0000_1040);
            end else begin
                chk("verr_vec_err", ADDR_W'(vec_err), 1);
                chk_pulse("verr");
                chk("verr_buf_vbr", ADDR_W'(buf_vbr), 1);
                chk("verr_retry_cnt", ADDR_W'(retry_cnt), 2);
                cyc();
                chk("verr_one_cycle", ADDR_W'(vec_err), 0);
                chk("verr_after_stall", ADDR_W'(stall), 0);
            end
        end

        // Address wrap, then data and error in the same cycle
        vbr = 32'hFFFF_FFF0; #1;
        chk("wrap_idle_enter", enter_addr, 32'hFFFF_FFF0);
        start_hv(12'd8);
        chk("wrap_retry_clr", ADDR_W'(retry_cnt), 0);
        cyc();
        ibus_idle = 1'b1; ibus_grnt = 1'b1; #1;
        chk("wrap_addr", ibus_addr, 32'h0000_0010);
        cyc();
        ibus_grnt = 1'b0; ibus_data_vld = 1'b1; ibus_acc_err = 1'b1;
        ibus_rdata = 32'h1234_5677;
        exp_q.push_back(32'h1234_5676);
        #1;
        chk_pulse("both");
        chk("both_succeed", ADDR_W'(vec_succeed), 1);
        cyc();
        ibus_data_vld = 1'b0; ibus_acc_err = 1'b0; #1;
        chk("both_stall", ADDR_W'(stall), 0);
        chk("both_retry", ADDR_W'(retry_cnt), 0);
        chk("both_vec_err", ADDR_W'(vec_err), 0);

        // No response in WAIT_DATA, then reset mid-fetch
        vbr = 32'h0000_1000;
        start_hv(12'd1);
        cyc();
        ibus_idle = 1'b1; ibus_grnt = 1'b1;
        cyc();
        ibus_grnt = 1'b0;
`ifdef CR_IU_VEC_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("tmo%0d_retry", i), ADDR_W'(retry_cnt), 0);
            chk($sformatf("tmo%0d_req", i), ADDR_W'(ibus_req), 0);
            cyc();
        end
        chk("tmo_retry_after", ADDR_W'(retry_cnt), 1);
        chk("tmo_req_after", ADDR_W'(ibus_req), 1);
        ibus_grnt = 1'b1;
        cyc();
        ibus_grnt = 1'b0;
`else
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("hang%0d_req", i), ADDR_W'(ibus_req), 0);
            chk($sformatf("hang%0d_retry", i), ADDR_W'(retry_cnt), 0);
            chk($sformatf("hang%0d_stall", i), ADDR_W'(stall), 1);
            cyc();
        end
`endif
        ibus_data_vld = 1'b1; ibus_rdata = 32'h0000_4444;
        cpurst_b = 1'b0; #1;
        chk("midrst_chgflw", ADDR_W'(chgflw_vld), 0);
        chk("midrst_reset_vld", ADDR_W'(reset_vld), 1);
        chk("midrst_succeed", ADDR_W'(vec_succeed), 0);
        chk("midrst_retry", ADDR_W'(retry_cnt), 0);
        cyc();
        chk("midrst_chgflw2", ADDR_W'(chgflw_vld), 0);
        ibus_data_vld = 1'b0; cpurst_b = 1'b1;
        cyc();
        chk("midrst_back_idle", ADDR_W'(reset_vld), 0);
        chk("midrst_idle_stall", ADDR_W'(stall), 0);

        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL sb_drain observed=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cr_iu_vec_fetch.md
CR_IU_VEC_FETCH -- requirements
Module: cr_iu_vec_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address/data width, range 16..32.
REQ-002 SHALL have parameter IDX_W, 12, interrupt-id width; table entry = 4 bytes.
REQ-003 SHALL have parameter MAX_RETRY, 2, table-fetch retries after bus error, range 0..7.
REQ-004 SHALL have parameter TMO_CYC, 64, WAIT_DATA timeout in cycles, range 2..255; used only under the macro.
REQ-005 SHALL have ports: misc_clk in 1, the only clock; cpurst_b in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: clk_en in 1, leave RESET; expt_vld in 1, retire exception/interrupt; expt_hv in 1, hardware-vectored; expt_id in IDX_W, interrupt id.
REQ-007 SHALL have ports: vbr in ADDR_W, table base; err_vbr in ADDR_W, error handler; ldst_wait in 1, outstanding ld/st; expt_taken in 1, pcgen took non-vectored entry.
REQ-008 SHALL have ports: ibus_idle in 1; ibus_grnt in 1; ibus_data_vld in 1; ibus_acc_err in 1; ibus_rdata in ADDR_W.
REQ-009 SHALL have outputs: ibus_req 1; ibus_addr ADDR_W; chgflw_vld 1; enter_addr ADDR_W; buf_vbr 1; stall 1; fetch_mask 1; reset_vld 1; vec_err 1; vec_succeed 1; retry_cnt 3.

Function
REQ-010 SHALL implement states RESET, IDLE, NV_WAIT, NV_IDLE, BUF, WAIT_IDLE, WAIT_GRANT, WAIT_DATA, VEC_ERR; cur_state updates on misc_clk.
REQ-011 RESET->IDLE when clk_en; IDLE: expt_vld&!expt_hv->NV_WAIT, expt_vld&expt_hv->BUF (id latched same edge), else IDLE.
REQ-012 NV_WAIT stays while ldst_wait, else NV_IDLE; NV_IDLE->IDLE on expt_taken.
REQ-013 BUF stays while ldst_wait, else WAIT_IDLE; WAIT_IDLE: ibus_idle&ibus_grnt->WAIT_DATA, ibus_idle&!ibus_grnt->WAIT_GRANT; WAIT_GRANT->WAIT_DATA on ibus_grnt.
REQ-014 WAIT_DATA: ibus_data_vld->IDLE (priority over error same cycle); ibus_acc_err with retry_cnt<MAX_RETRY->WAIT_IDLE, retry_cnt+1; ibus_acc_err at limit->VEC_ERR; VEC_ERR->IDLE after one cycle.
REQ-015 ibus_addr SHALL be ({vbr[ADDR_W-1:2],2'b00} + (id<<2)) mod 2^ADDR_W, wrap-around silent, held constant through all retries.
REQ-016 ibus_req SHALL be (WAIT_IDLE & ibus_idle) | WAIT_GRANT.
REQ-017 chgflw_vld SHALL pulse one cycle on WAIT_DATA&ibus_data_vld, on VEC_ERR, and on NV_IDLE&expt_taken.
REQ-018 enter_addr SHALL be {ibus_rdata[ADDR_W-1:1],1'b0} on data pulse, {err_vbr[ADDR_W-1:1],1'b0} in VEC_ERR, {vbr[ADDR_W-1:1],1'b0} otherwise.
REQ-019 buf_vbr SHALL assert on BUF->WAIT_IDLE, NV_IDLE->IDLE, and in VEC_ERR.
REQ-020 stall and fetch_mask SHALL equal (cur_state!=IDLE); reset_vld=(cur_state==RESET); vec_err=(cur_state==VEC_ERR); vec_succeed=WAIT_DATA&ibus_data_vld.
REQ-021 retry_cnt SHALL clear on IDLE->BUF and saturate at MAX_RETRY; expt_vld outside IDLE SHALL be ignored.

Reset
REQ-022 Reset SHALL force cur_state=RESET, retry_cnt=0, latched id=0, timeout counter=0; outputs: reset_vld=1, stall=1, fetch_mask=1, all pulses/ibus_req=0.
REQ-023 Reset mid-fetch SHALL abandon the transaction with no chgflw_vld pulse.

Configuration
REQ-024 With CR_IU_VEC_TIMEOUT_EN defined, a counter SHALL clear on WAIT_DATA entry and, after TMO_CYC cycles without data_vld/acc_err, act as ibus_acc_err (retry or VEC_ERR); without it, WAIT_DATA waits indefinitely and no counter exists.

Structure
REQ-025 State encodings (4-bit) and the 4-byte entry-size constant SHALL live in shared package cr_iu_vec_pkg.
REQ-026 Retry/timeout counting SHALL be sub-module cr_iu_vec_retry_cnt; FSM and address path remain in the top.

Verification
REQ-027 vbr=0x0000_1000, id=3, hv=1, grant in WAIT_IDLE, rdata=0x0000_2001 -> ibus_addr=0x100C, enter_addr=0x2000, chgflw_vld and vec_succeed one cycle.
REQ-028 hv=0, ldst_wait high 3 cycles, then expt_taken -> 4 NV_WAIT cycles, buf_vbr+chgflw_vld on NV_IDLE->IDLE, enter_addr=vbr.
REQ-029 MAX_RETRY=2, acc_err on 3 fetches -> retry_cnt 1,2, then VEC_ERR, enter_addr=err_vbr, vec_err one cycle.
REQ-030 vbr=0xFFFF_FFF0, id=8 -> ibus_addr=0x0000_0010 (wrap).
REQ-031 data_vld and acc_err same cycle -> success path, no retry.
REQ-032 Macro on, TMO_CYC=4, no response -> retry after 4 cycles; reset asserted in WAIT_DATA -> RESET, no chgflw_vld.
